dma_line_unpacker: RTL and testbench

Host-to-memory stage between the DMA read FIFO and the memory controller's DMA port. On a start pulse it pops `num_lines` 512-bit cache lines from the DMA read channel, splits each into sixteen 32-bit words, and writes them to consecutive word addresses starting at `base_addr`. It replaces ad-hoc word slicing in the DMA control path and reports `done` when the last word is accepted.

---
 rtl/dma_pkg.sv | 22 ++
 rtl/dma_line_unpacker.sv | 96 +++++++++
 tb/tb_dma_line_unpacker.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA line unpacker: default geometry, derived
// word-slicing constants, the control state encoding and the line-count type.
package dma_pkg;

  localparam int DEF_CL_WIDTH   = 512;
  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 28;
  localparam int DEF_SIZE_WIDTH = 43;

  localparam int WORDS_PER_LINE = DEF_CL_WIDTH / DEF_WORD_WIDTH;
  localparam int WORD_IDX_WIDTH = $clog2(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } t_unpack_state;

  typedef logic [DEF_SIZE_WIDTH-1:0] count_t;

endpackage

// File: rtl/dma_line_unpacker.sv
// Pops cache lines from the DMA read FIFO and writes them, one word at a
// time and least-significant word first, to consecutive memory word addresses.
module dma_line_unpacker
  import dma_pkg::*;
#(
  parameter int CL_WIDTH   = DEF_CL_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SIZE_WIDTH = DEF_SIZE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [SIZE_WIDTH-1:0] num_lines,
  input  logic                  dma_empty,
  input  logic [CL_WIDTH-1:0]   dma_rd_data,
  output logic                  dma_rd_en,
  input  logic                  mem_ready,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  done
);

  // Geometry is re-derived from the instance parameters so overrides stay
  // self-consistent; the package values describe the default build.
  localparam int WPL  = CL_WIDTH / WORD_WIDTH;
  localparam int IDXW = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WPL - 1);

  t_unpack_state         state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [SIZE_WIDTH-1:0] lines_left;
  logic [CL_WIDTH-1:0]   line_q;
  logic [IDXW-1:0]       word_idx;

  // Control FSM plus the address, line-count, line buffer and word-index state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      lines_left <= '0;
      word_idx   <= '0;
      // NOTE: the line buffer is a plain register, not a RAM, and it feeds
      // mem_data directly, so it is reset to keep that output at zero.
      line_q     <= '0;
    end else begin
      // NOTE: all state updates use <= so every branch sees pre-edge values.
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q     <= base_addr;
            lines_left <= num_lines;
            state      <= (num_lines == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (!dma_empty) begin
            line_q   <= dma_rd_data;
            word_idx <= '0;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            addr_q   <= addr_q + 1'b1;
            word_idx <= word_idx + 1'b1;
            if (word_idx == LAST_IDX) begin
              lines_left <= lines_left - 1'b1;
              state      <= (lines_left == SIZE_WIDTH'(1)) ? S_DONE : S_FETCH;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pop strobe follows the FIFO flag while waiting for a line; one pop per line.
  assign dma_rd_en = (state == S_FETCH) && !dma_empty;

  // Memory write port: decoded from state, address and data from registers.
  assign mem_en    = (state == S_WRITE);
  assign mem_wr_en = mem_en;
  assign mem_addr  = addr_q;
  assign mem_data  = line_q[WORD_WIDTH*word_idx +: WORD_WIDTH];

  // Status flags decoded from state.
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_dma_line_unpacker.sv
// Self-checking bench for dma_line_unpacker: table-driven transfers with a
// FIFO model and a write scoreboard, plus a mid-transfer reset sequence.
module tb_dma_line_unpacker;
  import dma_pkg::*;

  localparam int CLW = 512;
  localparam int WW  = 32;
  localparam int AW  = 28;
  localparam int SW  = 43;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [SW-1:0] num_lines;
  logic          dma_empty;
  logic [CLW-1:0] dma_rd_data;
  logic          dma_rd_en;
  logic          mem_ready;
  logic          mem_en;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_data;
  logic          busy;
  logic          done;

  dma_line_unpacker #(
    .CL_WIDTH(CLW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_lines(num_lines), .dma_empty(dma_empty), .dma_rd_data(dma_rd_data),
    .dma_rd_en(dma_rd_en), .mem_ready(mem_ready), .mem_en(mem_en),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] base;
    count_t        lines;
    int            gap;        // extra empty FETCH cycles before lines 2..n
    bit            toggle;     // mem_ready pattern 1,0,0,1
    bit            mid_start;  // pulse start with junk while busy
    int            exp_done;   // cycles from start to done; 0 = not checked
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [WW-1:0] d;
  } wr_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int pop_cnt = 0;
  int gap_cnt = 0;
  int gap_cfg = 0;
  bit toggle_cfg = 0;
  bit pop_pending = 0;
  bit prev_stall = 0;
  logic [AW-1:0] prev_addr;
  logic [WW-1:0] prev_data;
  logic [CLW-1:0] fifo_q[$];
  wr_t exp_q[$];
  int run_id = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Cycle counter (number of rising edges so far).
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FIFO and memory-ready model, updated just after each rising edge.
  initial begin
    dma_empty   = 1'b1;
    dma_rd_data = '0;
    mem_ready   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pending) begin
        pop_pending = 0;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        pop_cnt++;
        gap_cnt = (gap_cfg > 0) ? gap_cfg + 16 : 0;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
      if (toggle_cfg) mem_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else            mem_ready = 1'b1;
      dma_empty   = (fifo_q.size() == 0) || (gap_cnt != 0);
      dma_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      pop_pending = 0;
      prev_stall  = 0;
    end else begin
      if (prev_stall) begin
        check("hold_addr", mem_addr, prev_addr);
        check("hold_data", mem_data, prev_data);
      end
      if (dma_rd_en) check("pop_while_empty", dma_empty, 0);
      if (mem_en) check("wr_en_eq_en", mem_wr_en, 1);
      if (mem_en && mem_ready) begin
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.a);
          check("wr_data", mem_data, e.d);
        end
      end
      prev_stall  = mem_en && !mem_ready;
      prev_addr   = mem_addr;
      prev_data   = mem_data;
      pop_pending = dma_rd_en;
    end
  end

  // Queue the FIFO lines and the expected writes for one transfer.
  task automatic load(input vec_t v);
    for (int l = 0; l < int'(v.lines); l++) begin
      logic [CLW-1:0] line;
      for (int w = 0; w < 16; w++) begin
        wr_t e;
        e.d = 32'hA000_0000 + 32'(run_id << 12) + 32'(l << 4) + 32'(w);
        e.a = v.base + AW'(l * 16 + w);
        line[WW*w +: WW] = e.d;
        exp_q.push_back(e);
      end
      fifo_q.push_back(line);
    end
    run_id++;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input count_t n);
    start     = 1'b1;
    base_addr = b;
    num_lines = n;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = 28'h5A5A5A5;
    num_lines = 43'd9;
  endtask

  task automatic run(input vec_t v);
    int k;
    int p0;
    bit got;
    logic [AW-1:0] fa;
    gap_cfg    = v.gap;
    toggle_cfg = v.toggle;
    load(v);
    @(posedge clk);
    #1;
    k  = cyc;
    p0 = pop_cnt;
    pulse_start(v.base, v.lines);
    if (v.mid_start) begin
      repeat (5) @(posedge clk);
      #1;
      pulse_start(28'h000DEAD, 43'd7);
    end
    got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    check("done_seen", got, 1);
    if (v.exp_done != 0) check("done_cycle", cyc - k, v.exp_done);
    check("busy_at_done", busy, 1);
    fa = v.base + AW'(v.lines * 16);
    check("final_addr", mem_addr, fa);
    check("pops", pop_cnt - p0, v.lines);
    check("sb_drained", exp_q.size(), 0);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("done_one_cycle", done, 0);
  endtask

  vec_t vecs[6];

  initial begin
    vec_t rv;
    bit hit;
    vecs[0] = '{base: 28'h0000100, lines: 43'd1, gap: 0, toggle: 0, mid_start: 0, exp_done: 18};
    vecs[1] = '{base: 28'h0002000, lines: 43'd3, gap: 5, toggle: 0, mid_start: 0, exp_done: 62};
    vecs[2] = '{base: 28'h0000300, lines: 43'd1, gap: 0, toggle: 1, mid_start: 0, exp_done: 0};
    vecs[3] = '{base: 28'h0000400, lines: 43'd0, gap: 0, toggle: 0, mid_start: 0, exp_done: 1};
    vecs[4] = '{base: 28'hFFFFFF8, lines: 43'd1, gap: 0, toggle: 0, mid_start: 0, exp_done: 18};
    vecs[5] = '{base: 28'h0000500, lines: 43'd2, gap: 0, toggle: 0, mid_start: 1, exp_done: 35};

    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_lines = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_wr_en", mem_wr_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_dma_rd_en", dma_rd_en, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run(vecs[i]);

    // Reset during word 7 of line 2, then a clean restart.
    rv = '{base: 28'h0001000, lines: 43'd3, gap: 0, toggle: 0, mid_start: 0, exp_done: 0};
    gap_cfg = 0;
    toggle_cfg = 0;
    load(rv);
    @(posedge clk);
    #1;
    pulse_start(rv.base, rv.lines);
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_en && mem_addr == rv.base + 28'd23) begin
        hit = 1;
        break;
      end
    end
    check("reached_line2_word7", hit, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_mem_wr_en", mem_wr_en, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_data", mem_data, 0);
    check("mid_rst_dma_rd_en", dma_rd_en, 0);
    fifo_q.delete();
    exp_q.delete();
    gap_cnt = 0;
    pop_pending = 0;
    @(negedge clk);
    rst = 1'b0;
    rv = '{base: 28'h0007000, lines: 43'd1, gap: 0, toggle: 0, mid_start: 0, exp_done: 18};
    run(rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
